// File: rtl/ft601_rd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ft601_rd_ctrl: FT601 245-mode read burst controller with FWFT receive FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ft601_rd_ctrl #(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 4
) (
  input  logic                   rd_clk,
  input  logic                   rd_reset_n,
  input  logic                   ft_rxf_n,
  input  logic [31:0]            ft_data_in,
  input  logic [3:0]             ft_be_in,
  output logic                   ft_oe_n,
  output logic                   ft_rd_n,
  output logic [35:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_FULL  = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_LIMIT = c_LW'(DEPTH - MARGIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_READ = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_oe_n;
  logic            r_rd_n;
  logic            r_busy;
  logic            r_overrun;
  logic [35:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr_en;
  logic [c_LW-1:0] w_level_next;
  logic            w_room_now;
  logic            w_room_next;

  // A word is on the bus only when our registered strobe is low and the FT601 still has data
  assign w_push       = ~r_rd_n & ~ft_rxf_n;
  assign w_pop        = out_valid & out_ready;
  assign w_full       = (r_level == c_FULL);
  assign w_wr_en      = w_push & (~w_full | w_pop);
  assign w_level_next = r_level + c_LW'(w_wr_en) - c_LW'(w_pop);
  assign w_room_now   = (r_level < c_LIMIT);
  assign w_room_next  = (w_level_next < c_LIMIT);

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 36'h0;
  assign level     = r_level;
  assign overrun   = r_overrun;
  assign ft_oe_n   = r_oe_n;
  assign ft_rd_n   = r_rd_n;
  assign busy      = r_busy;

  // Storage is not reset; out_data is masked while the FIFO is empty
  always_ff @(posedge rd_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {ft_be_in, ft_data_in};
    end
  end

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_level <= w_level_next;
      if (w_push && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Outputs are loaded with the values belonging to the state being entered
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_state <= S_IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ft_rxf_n && w_room_now) begin
            r_state <= S_TURN;
            r_oe_n  <= 1'b0;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_TURN: begin
          r_state <= S_READ;
          r_oe_n  <= 1'b0;
          r_rd_n  <= 1'b0;
          r_busy  <= 1'b1;
        end
        S_READ: begin
          if (!ft_rxf_n && w_room_next) begin
            r_state <= S_READ;
            r_oe_n  <= 1'b0;
            r_rd_n  <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_END;
            r_oe_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_oe_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_oe_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
